// File: rtl/study_pkg.sv
// Shared types and constants for the study-mode index tracker.
package study_pkg;

  // Song-progress states of the tracker FSM.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_RELEASE,
    WAIT_PRESS,
    HOLD,
    DONE
  } state_t;

  // An all-zero key vector means no key is pressed.
  // On expected_note it also marks the end of the song.
  localparam int NO_NOTE = 0;

endpackage

// File: rtl/note_hold_filter.sv
// Debounce counter for a correct key press. It counts consecutive matching
// samples while the tracker is evaluating a press. It raises accept on the
// sample that completes HOLD_CYC matches.
module note_hold_filter #(
  parameter int HOLD_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,   // drop any partial hold (restart)
  input  logic match,   // player note equals the nonzero expected note
  input  logic active,  // tracker is in WAIT_PRESS or HOLD
  output logic accept,  // this sample completes the hold
  output logic bounce   // a started hold was broken this sample
);

  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam logic [CW:0] HOLD_V = HOLD_CYC[CW:0];

  logic [CW-1:0] cnt_q;
  logic [CW:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign accept  = active && match && (cnt_inc >= HOLD_V);
  assign bounce  = active && !match && (cnt_q != '0);

  // Count matching samples. Any break in the run, an accept or inactivity
  // returns the counter to zero, so every press starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt_q <= '0;
    else if (active && match && !accept)
      cnt_q <= cnt_inc[CW-1:0];
    else
      cnt_q <= '0;
  end

endmodule

// File: rtl/study_index_tracker.sv
// Study-mode song index tracker. It walks the song ROM one step per accepted,
// debounced correct press and requires a full release between presses.
// It counts wrong presses. In strict mode a wrong press restarts the song.
import study_pkg::*;

module study_index_tracker #(
  parameter int NOTE_W   = 10,
  parameter int IDX_W    = 8,
  parameter int SONG_LEN = 64,
  parameter int HOLD_CYC = 4,
  parameter int ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              strict_mode,
  input  logic [NOTE_W-1:0] expected_note,
  input  logic [NOTE_W-1:0] player_note,
  output logic [IDX_W-1:0]  index,
  output logic              hit_pulse,
  output logic              miss_pulse,
  output logic [ERR_W-1:0]  miss_count,
  output logic              busy,
  output logic              done
);

  localparam logic [NOTE_W-1:0] ZERO_NOTE = NOTE_W'(NO_NOTE);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SONG_LEN - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [ERR_W-1:0]   miss_q, miss_d;
  logic               hit_q, hit_d;
  logic               missp_q, missp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic player_zero, exp_zero, note_match;
  logic hold_active, hold_accept, hold_bounce;
  logic take_hit, take_miss;

  assign player_zero = (player_note == ZERO_NOTE);
  assign exp_zero    = (expected_note == ZERO_NOTE);
  assign note_match  = !exp_zero && (player_note == expected_note);
  assign hold_active = (state_q == WAIT_PRESS) || (state_q == HOLD);

  note_hold_filter #(.HOLD_CYC(HOLD_CYC)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .match  (note_match),
    .active (hold_active),
    .accept (hold_accept),
    .bounce (hold_bounce)
  );

  // Next-state, index and miss bookkeeping. start overrides every transition.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    miss_d    = miss_q;
    hit_d     = 1'b0;
    missp_d   = 1'b0;
    take_hit  = 1'b0;
    take_miss = 1'b0;

    if (start) begin
      state_d = WAIT_RELEASE;
      index_d = '0;
      miss_d  = '0;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_RELEASE: begin
          // The end marker wins over waiting for the key to be lifted.
          if (exp_zero)         state_d = DONE;
          else if (player_zero) state_d = WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (player_zero)      ;
          else if (hold_accept) take_hit  = 1'b1;
          else if (note_match)  state_d   = HOLD;
          else                  take_miss = 1'b1;
        end
        HOLD: begin
          if (hold_accept)                     take_hit  = 1'b1;
          else if (note_match)                 ;
          else if (hold_bounce && player_zero) state_d   = WAIT_PRESS;
          else                                 take_miss = 1'b1;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase

      if (take_hit) begin
        hit_d = 1'b1;
        if (index_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 1'b1;
          state_d = WAIT_RELEASE;
        end
      end

      if (take_miss) begin
        missp_d = 1'b1;
        if (miss_q != '1) miss_d = miss_q + 1'b1;
        if (strict_mode)  index_d = '0;
        state_d = WAIT_RELEASE;
      end
    end

    busy_d = (state_d == WAIT_RELEASE) || (state_d == WAIT_PRESS) ||
             (state_d == HOLD);
    done_d = (state_d == DONE);
  end

  // Register the state and every output. Reset has top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      miss_q  <= '0;
      hit_q   <= 1'b0;
      missp_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      miss_q  <= miss_d;
      hit_q   <= hit_d;
      missp_q <= missp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign index      = index_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = missp_q;
  assign miss_count = miss_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_study_index_tracker.sv
// Bench for study_index_tracker. It uses a HOLD_CYC=4 instance (a) and a
// HOLD_CYC=1 / ERR_W=2 instance (b), both with SONG_LEN=4. A song ROM array
// drives each instance.
module tb_study_index_tracker;
  localparam int NW = 10;
  localparam int IW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  // instance a
  logic          start_a, strict_a;
  logic [NW-1:0] pn_a, en_a;
  logic [IW-1:0] idx_a;
  logic          hit_a, miss_a, busy_a, done_a;
  logic [7:0]    mc_a;
  logic [NW-1:0] rom_a [4];
  // instance b
  logic          start_b, strict_b;
  logic [NW-1:0] pn_b, en_b;
  logic [IW-1:0] idx_b;
  logic          hit_b, miss_b, busy_b, done_b;
  logic [1:0]    mc_b;
  logic [NW-1:0] rom_b [4];

  assign en_a = (idx_a < 4) ? rom_a[idx_a[1:0]] : '0;
  assign en_b = (idx_b < 4) ? rom_b[idx_b[1:0]] : '0;

  study_index_tracker #(.NOTE_W(NW), .IDX_W(IW), .SONG_LEN(4), .HOLD_CYC(4), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .strict_mode(strict_a),
    .expected_note(en_a), .player_note(pn_a), .index(idx_a),
    .hit_pulse(hit_a), .miss_pulse(miss_a), .miss_count(mc_a),
    .busy(busy_a), .done(done_a));

  study_index_tracker #(.NOTE_W(NW), .IDX_W(IW), .SONG_LEN(4), .HOLD_CYC(1), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .strict_mode(strict_b),
    .expected_note(en_b), .player_note(pn_b), .index(idx_b),
    .hit_pulse(hit_b), .miss_pulse(miss_b), .miss_count(mc_b),
    .busy(busy_b), .done(done_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] idx, input logic hit, input logic miss,
                                     input logic [7:0] mc, input logic busy, input logic done);
    return {12'b0, idx, hit, miss, mc, busy, done};
  endfunction

  function automatic logic [31:0] pack_a();
    return pk(idx_a, hit_a, miss_a, mc_a, busy_a, done_a);
  endfunction

  // One clock of stimulus. Inputs change on the falling edge and outputs are
  // sampled 1 time unit after the rising edge.
  task automatic step_a(input logic [NW-1:0] p, input logic s, input logic st);
    @(negedge clk);
    pn_a = p; strict_a = s; start_a = st;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic [NW-1:0] p, input logic s, input logic st);
    @(negedge clk);
    pn_b = p; strict_b = s; start_b = st;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NW-1:0] player;
    logic [7:0]    idx;
    logic          hit, miss;
    logic [7:0]    mc;
    logic          busy, done;
  } vec_t;
  vec_t tbl[$];

  // Reference model of the song rules, written in terms of the song progress.
  int m_idx, m_mc, m_run;
  bit m_playing, m_fin, m_needrel, m_hit, m_miss;

  task automatic model_reset();
    m_idx = 0; m_mc = 0; m_run = 0;
    m_playing = 0; m_fin = 0; m_needrel = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_step(input int player, input bit strict, input bit st, input int exp_note);
    m_hit = 0; m_miss = 0;
    if (st) begin
      m_idx = 0; m_mc = 0; m_run = 0;
      m_playing = 1; m_fin = 0; m_needrel = 1;
    end else if (m_playing && !m_fin) begin
      if (m_needrel) begin
        if (exp_note == 0)    m_fin = 1;
        else if (player == 0) m_needrel = 0;
      end else if (player == 0) begin
        m_run = 0;
      end else if (player == exp_note) begin
        m_run++;
        if (m_run == 4) begin
          m_hit = 1; m_run = 0;
          if (m_idx == 3) m_fin = 1;
          else begin m_idx++; m_needrel = 1; end
        end
      end else begin
        m_miss = 1; m_run = 0;
        if (m_mc < 255) m_mc++;
        if (strict) m_idx = 0;
        m_needrel = 1;
      end
    end
  endtask

  initial begin
    int h, ms;
    logic [NW-1:0] note, cur_exp;
    int dur;
    bit s;

    rst = 1'b1;
    start_a = 0; strict_a = 0; pn_a = '0;
    start_b = 0; strict_b = 0; pn_b = '0;
    rom_a = '{10'h011, 10'h022, 10'h033, 10'h044};
    rom_b = '{10'h011, 10'h022, 10'h033, 10'h044};

    // 1. reset, then key presses without start are ignored
    step_a('0, 0, 0);
    step_a('0, 0, 0);
    chk("reset_a", pack_a(), pk(0, 0, 0, 0, 0, 0));
    chk("reset_b", {idx_b, hit_b, miss_b, mc_b, busy_b, done_b}, 0);
    rst = 1'b0;
    h = 0;
    for (int i = 0; i < 6; i++) begin
      step_a(10'h011, 0, 0);
      if (hit_a || miss_a) h++;
    end
    chk("idle_no_effect", pack_a(), pk(0, 0, 0, 0, 0, 0));
    chk("idle_no_pulse", h, 0);

    // 2. correct play, table driven
    step_a('0, 0, 1);
    chk("start_busy", pack_a(), pk(0, 0, 0, 0, 1, 0));
    for (int n = 0; n < 4; n++) begin
      tbl.push_back('{player: '0, idx: 8'(n), hit: 0, miss: 0, mc: 0, busy: 1, done: 0});
      for (int k = 1; k <= 4; k++) begin
        bit last;
        last = (k == 4);
        tbl.push_back('{player: rom_a[n],
                        idx: last ? ((n == 3) ? 8'd3 : 8'(n + 1)) : 8'(n),
                        hit: last, miss: 0, mc: 0,
                        busy: !(last && n == 3), done: last && n == 3});
      end
    end
    tbl.push_back('{player: '0, idx: 8'd3, hit: 0, miss: 0, mc: 0, busy: 0, done: 1});
    foreach (tbl[i]) begin
      step_a(tbl[i].player, 0, 0);
      chk($sformatf("play_row%0d", i), pack_a(),
          pk(tbl[i].idx, tbl[i].hit, tbl[i].miss, tbl[i].mc, tbl[i].busy, tbl[i].done));
    end

    // 3. held key counts once; a bounce is not a miss
    step_a('0, 0, 1);
    step_a('0, 0, 0);
    h = 0; ms = 0;
    for (int i = 0; i < 10; i++) begin
      step_a(10'h011, 0, 0);
      h += int'(hit_a); ms += int'(miss_a);
    end
    chk("held_hits", h, 1);
    chk("held_idx", idx_a, 1);
    step_a('0, 0, 0);
    h = 0;
    step_a(10'h022, 0, 0); h += int'(hit_a); ms += int'(miss_a);
    step_a(10'h022, 0, 0); h += int'(hit_a); ms += int'(miss_a);
    step_a('0, 0, 0);      h += int'(hit_a); ms += int'(miss_a);
    for (int i = 0; i < 4; i++) begin
      step_a(10'h022, 0, 0);
      h += int'(hit_a); ms += int'(miss_a);
    end
    chk("bounce_hits", h, 1);
    chk("bounce_no_miss", ms, 0);
    chk("bounce_state", pack_a(), pk(2, 1, 0, 0, 1, 0));

    // 4. wrong note, lenient then strict
    step_a('0, 0, 0);
    step_a(10'h055, 0, 0);
    chk("miss_lenient", pack_a(), pk(2, 0, 1, 1, 1, 0));
    step_a('0, 1, 0);
    step_a(10'h055, 1, 0);
    chk("miss_strict", pack_a(), pk(0, 0, 1, 2, 1, 0));

    // 6a. end marker at index 1
    rom_a = '{10'h011, 10'h000, 10'h033, 10'h044};
    step_a('0, 0, 1);
    step_a('0, 0, 0);
    for (int i = 0; i < 4; i++) step_a(10'h011, 0, 0);
    chk("endmark_hit", pack_a(), pk(1, 1, 0, 0, 1, 0));
    step_a('0, 0, 0);
    chk("endmark_done", pack_a(), pk(1, 0, 0, 0, 0, 1));
    rom_a = '{10'h011, 10'h022, 10'h033, 10'h044};

    // 5. saturation on ERR_W=2, then restart
    step_b('0, 0, 1);
    step_b('0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step_b(10'h055, 0, 0);
      step_b('0, 0, 0);
    end
    chk("sat_count", mc_b, 3);
    step_b('0, 0, 1);
    chk("sat_restart", {mc_b, idx_b, busy_b}, {2'd0, 8'd0, 1'b1});

    // 6b. HOLD_CYC=1: a single matching sample is accepted at the next edge
    step_b('0, 0, 0);
    step_b(10'h011, 0, 0);
    chk("hold1_hit", {idx_b, hit_b, miss_b}, {8'd1, 1'b1, 1'b0});

    // randomized play against the reference model
    rst = 1'b1;
    step_a('0, 0, 0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) rom_a[i] = NW'($urandom_range(1, 1023));
    model_step(0, 0, 1, int'(rom_a[0]));
    step_a('0, 0, 1);
    chk("rnd_start", pack_a(), pk(8'(m_idx), m_hit, m_miss, 8'(m_mc), m_playing && !m_fin, m_fin));
    for (int seg = 0; seg < 250; seg++) begin
      int r;
      r = $urandom_range(0, 99);
      s = 1'($urandom_range(0, 1));
      cur_exp = rom_a[m_idx];
      if (r < 4) begin
        model_step(0, s, 1, int'(cur_exp));
        step_a('0, s, 1);
        chk($sformatf("rnd_seg%0d_start", seg), pack_a(),
            pk(8'(m_idx), m_hit, m_miss, 8'(m_mc), m_playing && !m_fin, m_fin));
      end else begin
        if (r < 35)      note = '0;
        else if (r < 85) note = cur_exp;
        else begin
          note = NW'($urandom_range(1, 1023));
          while (note == cur_exp) note = NW'($urandom_range(1, 1023));
        end
        dur = $urandom_range(1, 6);
        for (int c = 0; c < dur; c++) begin
          model_step(int'(note), s, 0, int'(rom_a[m_idx]));
          step_a(note, s, 0);
          chk($sformatf("rnd_seg%0d_c%0d", seg, c), pack_a(),
              pk(8'(m_idx), m_hit, m_miss, 8'(m_mc), m_playing && !m_fin, m_fin));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/study_index_tracker.md
Name: study_index_tracker

Overview:
Parametrised next-generation study-mode index tracker for the piano game.
- Compares the player's key vector against the expected note of the current song step.
- Advances the song index only on a held, debounced correct press followed by a full release.
- Counts wrong presses and optionally restarts on error (strict mode).
- Flags song completion.
- Sits between the key-input/debounce layer and the song ROM; `index` addresses the ROM, and the ROM's output is returned on `expected_note`.

Parameters:
- NOTE_W, 10: width of note/pitch vectors; value 0 means "no key pressed".
- IDX_W, 8: width of `index`.
- SONG_LEN, 64: number of steps; the last valid index is SONG_LEN-1; must satisfy SONG_LEN <= 2**IDX_W.
- HOLD_CYC, 4: consecutive matching cycles required to accept a press; must be >= 1.
- ERR_W, 8: width of the saturating miss counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  restart song from index 0; one-cycle pulse.
- strict_mode  in  1  1 = a wrong press returns index to 0.
- expected_note  in  NOTE_W  song ROM output at `index`; 0 = end-of-song marker.
- player_note  in  NOTE_W  current key vector from input layer.
- index  out  IDX_W  current song step.
- hit_pulse  out  1  one-cycle pulse on accepted correct press.
- miss_pulse  out  1  one-cycle pulse on wrong press.
- miss_count  out  ERR_W  wrong presses since start; saturates at all-ones.
- busy  out  1  high in WAIT_RELEASE, WAIT_PRESS and HOLD.
- done  out  1  high in DONE.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge):
  - state = IDLE.
  - index, miss_count, hit_pulse, miss_pulse, busy, done and the hold counter all = 0.
  - rst has priority over everything.
- start has priority over all FSM transitions except rst:
  - From any state: index=0, miss_count=0, hold counter=0, pulses=0.
  - Next state is WAIT_RELEASE.
- States:
  - IDLE: wait for start.
  - WAIT_RELEASE: stay until player_note == 0, then go to WAIT_PRESS. This prevents a held key from counting twice. If expected_note == 0 here, go to DONE.
  - WAIT_PRESS:
    - player_note == 0: stay.
    - player_note == expected_note (nonzero): hold counter = 1. If HOLD_CYC == 1, accept immediately (see Accept); otherwise go to HOLD.
    - Any other nonzero value: Miss.
  - HOLD:
    - player_note == expected_note: counter++. When the counter reaches HOLD_CYC, Accept.
    - player_note == 0: return to WAIT_PRESS with counter = 0. This is a bounce, not a miss.
    - Other nonzero value: Miss.
  - DONE: done=1, busy=0, index frozen; leave only on start or rst.
- Accept:
  - hit_pulse=1 for one cycle.
  - If index == SONG_LEN-1: index is held and the next state is DONE.
  - Else: index+1 and the next state is WAIT_RELEASE.
- Miss:
  - miss_pulse=1 for one cycle.
  - miss_count+1, saturating at 2**ERR_W-1.
  - If strict_mode: index=0.
  - Next state is WAIT_RELEASE.
  - strict_mode is sampled in the cycle the miss is detected.
- Latency:
  - hit_pulse and the index update appear at the clk edge after the HOLD_CYC-th consecutive matching sample.
  - miss_pulse appears at the edge after the first mismatching nonzero sample.
- No wrap-around: index never exceeds SONG_LEN-1.
- hit_pulse and miss_pulse are never high in the same cycle.
- A mid-song rst or start discards the partial hold and pending pulses.
- The hold counter width is $clog2(HOLD_CYC+1).

Decomposition:
- Shared package `study_pkg`:
  - state enum: IDLE, WAIT_RELEASE, WAIT_PRESS, HOLD, DONE.
  - constant NO_NOTE = '0.
- Sub-module `note_hold_filter`:
  - Inputs: clk, rst, clear, match, active.
  - Outputs: accept, bounce.
  - Owns the hold counter.
- The FSM, index and miss logic stay in the top module.

Test Plan:
All cases use SONG_LEN=4, HOLD_CYC=4, unless stated otherwise.
1. Reset and idle: rst for 2 cycles, then idle -> index=0, miss_count=0, busy=0, done=0. Without start, key presses have no effect.
2. Correct play: start; ROM {0x011,0x022,0x033,0x044}; each note held 4 cycles then released.
   -> hit_pulse ×4, each the edge after the 4th matching cycle.
   -> index 0→1→2→3; done=1 after the 4th hit; index stays 3.
3. Held key and bounce:
   - Hold 0x011 for 10 cycles -> exactly one hit; index=1.
   - Then 0x022 for 2 cycles, 0 for 1 cycle, 0x022 for 4 cycles -> no miss; one hit; index=2.
4. Wrong note, lenient vs strict: at index=2, press 0x055.
   - strict_mode=0 -> miss_pulse, miss_count=1, index=2.
   - Repeat with strict_mode=1 -> miss_count=2, index=0.
5. Saturation and restart: ERR_W=2, 5 wrong presses -> miss_count=3. Then start -> miss_count=0, index=0, busy=1.
6. End marker and HOLD_CYC=1 variant: expected_note=0 at index 1 -> DONE after index 1 is reached. With HOLD_CYC=1, a single-cycle correct press -> hit on the next edge.
